// File: rtl/valrdyqueue_pkg.sv
// Shared definitions for the val/rdy queue controller.
//   queue_state_t : occupancy state of the queue (empty / partial / full)
//   ptr_width()   : pointer width needed to index a given queue depth
package valrdyqueue_pkg;

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PARTIAL = 2'd1,
        S_FULL    = 2'd2
    } queue_state_t;

    // Smallest width that can index n entries; never less than 1 bit.
    function automatic int ptr_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ff.sv
// Enabled flip-flop cell with synchronous active-high reset to zero.
//   CLK   : clock, rising edge
//   RESET : synchronous reset, has priority over EN
//   EN    : load enable
//   D     : next value, loaded when EN is high
//   Q     : registered value
module ff #(
    parameter int W = 1
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         EN,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (RESET) begin
            q_d = '0;
        end else if (EN) begin
            q_d = D;
        end
    end

    always_ff @(posedge CLK) begin
        q_q <= q_d;
    end

    assign Q = q_q;

endmodule

// File: rtl/valrdy_queue_ptr.sv
// Wrap-around pointer register for the queue head/tail.
//   CLK   : clock, rising edge
//   RESET : synchronous reset, pointer returns to 0
//   INC   : advance pointer by one; wraps by natural overflow of PTR_W bits
//   PTR   : current pointer value
module valrdy_queue_ptr #(
    parameter int PTR_W = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             INC,
    output logic [PTR_W-1:0] PTR
);

    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = PTR + PTR_W'(1);
    end

    ff #(.W(PTR_W)) u_ptr_ff (
        .CLK   (CLK),
        .RESET (RESET),
        .EN    (INC),
        .D     (ptr_d),
        .Q     (PTR)
    );

endmodule

// File: rtl/valrdy_queue_ctrl.sv
// Val/rdy normal queue controller with reference data storage.
// Tracks head/tail pointers, occupancy and an occupancy state machine,
// and drives per-entry write enables and the head read select.
//   CLK, RESET : clock and synchronous active-high reset
//   RECV_VAL   : upstream message valid
//   RECV_MSG   : upstream message data
//   RECV_RDY   : queue accepts a message this cycle
//   SEND_VAL   : head entry holds a valid message
//   SEND_MSG   : head entry data (output mux)
//   SEND_RDY   : downstream takes the head message this cycle
//   WEN        : one-hot entry write enable
//   RADDR      : head entry index
//   COUNT      : occupancy 0..NUM_ENTRIES
//   FULL/EMPTY : occupancy flags, decoded from the state register
module valrdy_queue_ctrl
    import valrdyqueue_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int DATA_W      = 8
) (
    input  logic                                   CLK,
    input  logic                                   RESET,
    input  logic                                   RECV_VAL,
    input  logic [DATA_W-1:0]                      RECV_MSG,
    output logic                                   RECV_RDY,
    output logic                                   SEND_VAL,
    output logic [DATA_W-1:0]                      SEND_MSG,
    input  logic                                   SEND_RDY,
    output logic [NUM_ENTRIES-1:0]                 WEN,
    output logic [ptr_width(NUM_ENTRIES)-1:0]      RADDR,
    output logic [ptr_width(NUM_ENTRIES):0]        COUNT,
    output logic                                   FULL,
    output logic                                   EMPTY
);

    localparam int PTR_W = ptr_width(NUM_ENTRIES);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0] CNT_LAST = (PTR_W + 1)'(NUM_ENTRIES - 1);

    queue_state_t     state_d;
    queue_state_t     state_q;
    logic [PTR_W:0]   count_d;
    logic [PTR_W:0]   count_q;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    logic             full;
    logic             empty;
    logic             recv_rdy;
    logic             send_val;
    logic             enq;
    logic             deq;
    logic [NUM_ENTRIES-1:0] wen;

    // Handshakes. Readiness comes only from registered state, so RECV_RDY
    // never sees SEND_RDY and SEND_VAL never sees RECV_VAL.
    assign enq = RECV_VAL & recv_rdy;
    assign deq = send_val & SEND_RDY;

    valrdy_queue_ptr #(.PTR_W(PTR_W)) u_wptr (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (enq),
        .PTR   (wptr)
    );

    valrdy_queue_ptr #(.PTR_W(PTR_W)) u_rptr (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (deq),
        .PTR   (rptr)
    );

    // State register
    always_ff @(posedge CLK) begin
        state_q <= state_d;
        count_q <= count_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (RESET) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (enq) begin
                        state_d = S_PARTIAL;
                    end
                end
                S_PARTIAL: begin
                    if (enq && !deq && (count_q == CNT_LAST)) begin
                        state_d = S_FULL;
                    end else if (deq && !enq && (count_q == CNT_ONE)) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (deq) begin
                        state_d = S_PARTIAL;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (RESET) begin
            count_d = '0;
        end else if (enq && !deq) begin
            count_d = count_q + CNT_ONE;
        end else if (deq && !enq) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Output logic
    always_comb begin
        full     = (state_q == S_FULL);
        empty    = (state_q == S_EMPTY);
        recv_rdy = !full && !RESET;
        send_val = !empty && !RESET;
        wen      = '0;
        if (enq) begin
            wen[wptr] = 1'b1;
        end
    end

    assign RECV_RDY = recv_rdy;
    assign SEND_VAL = send_val;
    assign WEN      = wen;
    assign RADDR    = rptr;
    assign COUNT    = count_q;
    assign FULL     = full;
    assign EMPTY    = empty;

    // Reference storage: entries are not cleared on reset; the pointers
    // alone define which contents are live.
    logic [DATA_W-1:0] entry_q [NUM_ENTRIES];

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
        ff #(.W(DATA_W)) u_entry (
            .CLK   (CLK),
            .RESET (1'b0),
            .EN    (wen[i]),
            .D     (RECV_MSG),
            .Q     (entry_q[i])
        );
    end

    assign SEND_MSG = entry_q[rptr];

endmodule

// File: tb/tb_valrdy_queue_ctrl.sv
module tb_valrdy_queue_ctrl;

    localparam int N = 4;

    logic       CLK;
    logic       RESET;
    logic       RECV_VAL;
    logic [7:0] RECV_MSG;
    logic       RECV_RDY;
    logic       SEND_VAL;
    logic [7:0] SEND_MSG;
    logic       SEND_RDY;
    logic [3:0] WEN;
    logic [1:0] RADDR;
    logic [2:0] COUNT;
    logic       FULL;
    logic       EMPTY;

    valrdy_queue_ctrl #(.NUM_ENTRIES(N), .DATA_W(8)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .RECV_VAL (RECV_VAL),
        .RECV_MSG (RECV_MSG),
        .RECV_RDY (RECV_RDY),
        .SEND_VAL (SEND_VAL),
        .SEND_MSG (SEND_MSG),
        .SEND_RDY (SEND_RDY),
        .WEN      (WEN),
        .RADDR    (RADDR),
        .COUNT    (COUNT),
        .FULL     (FULL),
        .EMPTY    (EMPTY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model
    int         m_cnt;
    int         m_wptr;
    int         m_rptr;
    logic [7:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_wptr = 0;
        m_rptr = 0;
        sb.delete();
    endtask

    // One clock of stimulus; called 1 ns after a rising edge.
    task automatic cycle(input logic rv, input logic [7:0] msg, input logic sr);
        logic       e_enq;
        logic       e_deq;
        logic [7:0] e_msg;
        RECV_VAL = rv;
        RECV_MSG = msg;
        SEND_RDY = sr;
        #1;
        e_enq = rv && (m_cnt < N);
        e_deq = sr && (m_cnt > 0);
        chk("recv_rdy", 32'(RECV_RDY), 32'(m_cnt < N));
        chk("send_val", 32'(SEND_VAL), 32'(m_cnt > 0));
        chk("count",    32'(COUNT),    32'(m_cnt));
        chk("raddr",    32'(RADDR),    32'(m_rptr));
        chk("wen",      32'(WEN),      e_enq ? (32'd1 << m_wptr) : 32'd0);
        chk("full",     32'(FULL),     32'(m_cnt == N));
        chk("empty",    32'(EMPTY),    32'(m_cnt == 0));
        chk("full_vs_count",  32'(FULL),  32'(COUNT == 3'(N)));
        chk("empty_vs_count", 32'(EMPTY), 32'(COUNT == 3'd0));
        if (e_deq) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e_msg = sb.pop_front();
                chk("send_msg", 32'(SEND_MSG), 32'(e_msg));
            end
        end
        if (e_enq) begin
            sb.push_back(msg);
            m_wptr = (m_wptr + 1) % N;
        end
        if (e_deq) begin
            m_rptr = (m_rptr + 1) % N;
        end
        m_cnt = m_cnt + int'(e_enq) - int'(e_deq);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input logic rv);
        RESET    = 1'b1;
        RECV_VAL = rv;
        RECV_MSG = 8'hEE;
        SEND_RDY = 1'b1;
        #1;
        chk("rst_recv_rdy", 32'(RECV_RDY), 32'd0);
        chk("rst_send_val", 32'(SEND_VAL), 32'd0);
        chk("rst_wen",      32'(WEN),      32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
    endtask

    initial begin
        RESET    = 1'b1;
        RECV_VAL = 1'b0;
        RECV_MSG = 8'h00;
        SEND_RDY = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;

        // Reset with RECV_VAL high, then idle
        do_reset(1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Fill with downstream stalled
        cycle(1'b1, 8'hA1, 1'b0);
        cycle(1'b1, 8'hA2, 1'b0);
        cycle(1'b1, 8'hA3, 1'b0);
        cycle(1'b1, 8'hA4, 1'b0);
        // Fifth message refused
        cycle(1'b1, 8'hA5, 1'b0);
        // Full with simultaneous deq: no enq that cycle
        cycle(1'b1, 8'hA6, 1'b1);
        // Drain the rest (first of these sees COUNT=3, RECV_RDY=1)
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Streaming from empty, pointers wrap twice
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'(i), 1'b1);
        end
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Empty boundary: no same-cycle forwarding
        cycle(1'b1, 8'h55, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        // Reset mid-operation
        cycle(1'b1, 8'hB1, 1'b0);
        cycle(1'b1, 8'hB2, 1'b0);
        cycle(1'b1, 8'hB3, 1'b0);
        chk("pre_rst_count", 32'(COUNT), 32'd3);
        do_reset(1'b0);
        cycle(1'b1, 8'h77, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
